operand_fetch_stage: RTL
========================

Name: operand_fetch_stage

Overview:
- Decode-to-execute pipeline stage sitting directly downstream of the register file.
- Drives the register file read sources and consumes both read ports.
- Resolves data hazards: bypasses results from EX, MEM and WB, and stalls one cycle on load-use.
- Holds the ID/EX pipeline register, with valid/ready handshakes on both sides.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- REG_ADDR_WIDTH, 5, register index width; register 0 is hardwired zero.

Ports:
- Clock  in  1  rising-edge clock, shared with the register file.
- Reset  in  1  synchronous, active-high.
- Flush  in  1  kill the held instruction (branch redirect).
- InValid  in  1  decode presents an instruction.
- InReady  out  1  stage accepts the instruction this cycle.
- InRs  in  5  source A index.
- InRt  in  5  source B index.
- InRd  in  5  destination index.
- InImm  in  32  sign-extended immediate.
- InUseImm  in  1  operand B is the immediate; source B is then not needed.
- InIsLoad  in  1  instruction is a load.
- InRegWrite  in  1  instruction writes a register.
- RfSourceA  out  5  equals InRs (combinational).
- RfSourceB  out  5  equals InRt (combinational).
- RfPortA  in  32  register file read data for source A.
- RfPortB  in  32  register file read data for source B.
- ExResult  in  32  ALU result of the instruction currently in this stage's output register.
- MemDest  in  5  MEM stage destination.
- MemRegWrite  in  1  MEM stage writes a register.
- MemResult  in  32  MEM stage result.
- WbDest  in  5  the register file WriteTarget.
- WbWriteEnable  in  1  the register file WriteEnable.
- WbData  in  32  the register file WriteData.
- OutValid  out  1  execute-side instruction valid.
- OutReady  in  1  execute accepts.
- OutOperandA  out  32  registered operand A.
- OutOperandB  out  32  registered operand B (immediate or register).
- OutStoreData  out  32  registered forwarded rt value.
- OutDest  out  5  registered destination.
- OutRegWrite  out  1  registered write flag.
- OutIsLoad  out  1  registered load flag.

Behaviour:
- Reset: every Out* register is 0. InReady is 0 during the reset cycle.
- Forwarding, per source, combinational, priority order:
  1. Index 0 reads 0; index 0 is never forwarded.
  2. EX: OutValid && OutRegWrite && !OutIsLoad && OutDest==idx -> ExResult.
  3. MEM: MemRegWrite && MemDest==idx -> MemResult.
  4. WB: WbWriteEnable && WbDest==idx -> WbData. This covers the register file's write-then-read in the same cycle.
  5. Otherwise RfPortA / RfPortB.
- Load-use hazard: Hazard = InValid && OutValid && OutIsLoad && OutDest!=0 && (OutDest==InRs || (!InUseImm && OutDest==InRt)).
- Advance = !OutValid || OutReady.
- InReady = Advance && !Hazard && !Reset.
- Register update, first matching rule wins:
  - Reset: clear all outputs.
  - Flush: OutValid <= 0. The input is not captured even if InValid; InReady is still 1 but the flush kills the instruction. Decode must also flush.
  - Advance && Hazard: insert a bubble. OutValid <= 0; the input is held for the next cycle. Exactly one bubble per load-use, because the load then moves to MEM and is forwarded via MemResult.
  - Advance && InValid: capture forwarded A into OutOperandA. OutOperandB <= InUseImm ? InImm : forwarded B. OutStoreData <= forwarded B. Capture Rd/RegWrite/IsLoad. OutValid <= 1.
  - Advance && !InValid: OutValid <= 0.
  - Otherwise (OutValid && !OutReady): hold all outputs unchanged.
- Latency: 1 cycle from accept to OutValid. Throughput: 1 per cycle with no hazards.
- Out* payload is don't-care when OutValid=0, but it is deterministic (holds last value).
- Flush and Hazard in the same cycle: Flush wins, no bubble accounting.

Optional Feature:
- Macro: OPERAND_FETCH_STATS_EN.
- Defined:
  - Adds output StallCount (32) and output ForwardCount (32), both reset to 0.
  - StallCount increments on every cycle with Advance && Hazard && !Flush.
  - ForwardCount increments on every accepted instruction with at least one source taken from EX/MEM/WB.
  - Both counters saturate at 0xFFFFFFFF.
  - Both counters clear on Reset only.
- Not defined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then InValid=1, InRs=3, InRt=4, RfPortA=0x11, RfPortB=0x22, OutReady=1 -> next cycle OutValid=1, OutOperandA=0x11, OutOperandB=0x22.
- Held output: non-load, OutDest=5. New instruction with InRs=5, ExResult=0xAAAA, MemDest=5, MemResult=0xBBBB -> OutOperandA=0xAAAA (EX priority). Repeat with InRs=0 -> OutOperandA=0.
- Load-use: load to r7 accepted, then add with InRs=7 -> cycle 1: InReady=0, OutValid=0 bubble. Cycle 2: MemDest=7, MemResult=0x1234 -> add accepted, OutOperandA=0x1234. With InUseImm=1 and InRt=7, InRs=2 -> no stall.
- WB bypass: WbWriteEnable=1, WbDest=9, WbData=0xDEAD, RfPortA=0 (stale), InRs=9 -> OutOperandA=0xDEAD.
- Backpressure: OutReady=0 for 3 cycles with OutValid=1 -> InReady=0, outputs unchanged. OutReady=1 -> next instruction captured the following cycle.
- Flush with InValid=1 and OutValid=1 -> next cycle OutValid=0. With OPERAND_FETCH_STATS_EN defined, one load-use stall gives StallCount=1.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// ---------------------------------------------------------------------------
// operand_fetch_stage
//
// Decode-to-execute pipeline stage placed directly after the register file.
// It presents the decode source indices to the register file, resolves
// operand hazards by bypassing results from EX, MEM and WB, inserts a single
// bubble on a load-use dependency, and holds the ID/EX pipeline register
// with valid/ready handshakes on both sides.
//
// Optional build feature (macro OPERAND_FETCH_STATS_EN):
//   adds saturating 32-bit counters o_stall_count and o_forward_count.
//
// Ports:
//   i_clk, i_reset         clock (shared with register file), sync active-high reset
//   i_flush                kill the instruction held in the output register
//   i_in_valid/o_in_ready  decode-side handshake
//   i_in_rs/rt/rd          source A, source B, destination indices
//   i_in_imm, i_in_use_imm immediate and "operand B is the immediate"
//   i_in_is_load           instruction is a load
//   i_in_reg_write         instruction writes a register
//   o_rf_source_a/b        register file read indices (combinational)
//   i_rf_port_a/b          register file read data
//   i_ex_result            ALU result of the instruction held in this stage
//   i_mem_*                MEM stage destination / write flag / result
//   i_wb_*                 register file write port (WB stage)
//   o_out_valid/i_out_ready execute-side handshake
//   o_out_*                registered operands and instruction controls
// ---------------------------------------------------------------------------
module operand_fetch_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_flush,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [REG_ADDR_WIDTH-1:0] i_in_rs,
  input  logic [REG_ADDR_WIDTH-1:0] i_in_rt,
  input  logic [REG_ADDR_WIDTH-1:0] i_in_rd,
  input  logic [DATA_WIDTH-1:0]     i_in_imm,
  input  logic                      i_in_use_imm,
  input  logic                      i_in_is_load,
  input  logic                      i_in_reg_write,
  output logic [REG_ADDR_WIDTH-1:0] o_rf_source_a,
  output logic [REG_ADDR_WIDTH-1:0] o_rf_source_b,
  input  logic [DATA_WIDTH-1:0]     i_rf_port_a,
  input  logic [DATA_WIDTH-1:0]     i_rf_port_b,
  input  logic [DATA_WIDTH-1:0]     i_ex_result,
  input  logic [REG_ADDR_WIDTH-1:0] i_mem_dest,
  input  logic                      i_mem_reg_write,
  input  logic [DATA_WIDTH-1:0]     i_mem_result,
  input  logic [REG_ADDR_WIDTH-1:0] i_wb_dest,
  input  logic                      i_wb_write_enable,
  input  logic [DATA_WIDTH-1:0]     i_wb_data,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [DATA_WIDTH-1:0]     o_out_operand_a,
  output logic [DATA_WIDTH-1:0]     o_out_operand_b,
  output logic [DATA_WIDTH-1:0]     o_out_store_data,
  output logic [REG_ADDR_WIDTH-1:0] o_out_dest,
  output logic                      o_out_reg_write,
`ifdef OPERAND_FETCH_STATS_EN
  output logic [31:0]               o_stall_count,
  output logic [31:0]               o_forward_count,
`endif
  output logic                      o_out_is_load
);

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_IDX = {REG_ADDR_WIDTH{1'b0}};

  logic                      r_out_valid;
  logic [DATA_WIDTH-1:0]     r_out_operand_a;
  logic [DATA_WIDTH-1:0]     r_out_operand_b;
  logic [DATA_WIDTH-1:0]     r_out_store_data;
  logic [REG_ADDR_WIDTH-1:0] r_out_dest;
  logic                      r_out_reg_write;
  logic                      r_out_is_load;

  logic [DATA_WIDTH-1:0]     w_fwd_a;
  logic [DATA_WIDTH-1:0]     w_fwd_b;
  logic                      w_hit_a;
  logic                      w_hit_b;
  logic                      w_hazard;
  logic                      w_advance;

  // Bypass mux for one source: returns {taken_from_pipeline, value}.
  // A load in EX has no result yet, so it is excluded from the EX bypass;
  // the load-use bubble covers that case.
  function automatic logic [DATA_WIDTH:0] forward_operand(
    input logic [REG_ADDR_WIDTH-1:0] idx,
    input logic [DATA_WIDTH-1:0]     rf_data
  );
    logic [DATA_WIDTH:0] result;
    if (idx == ZERO_IDX) begin
      result = {1'b0, {DATA_WIDTH{1'b0}}};
    end else if (r_out_valid && r_out_reg_write && !r_out_is_load && (r_out_dest == idx)) begin
      result = {1'b1, i_ex_result};
    end else if (i_mem_reg_write && (i_mem_dest == idx)) begin
      result = {1'b1, i_mem_result};
    end else if (i_wb_write_enable && (i_wb_dest == idx)) begin
      result = {1'b1, i_wb_data};
    end else begin
      result = {1'b0, rf_data};
    end
    return result;
  endfunction

  assign o_rf_source_a = i_in_rs;
  assign o_rf_source_b = i_in_rt;

  // Resolve both operands through the bypass network.
  always_comb begin
    {w_hit_a, w_fwd_a} = forward_operand(i_in_rs, i_rf_port_a);
    {w_hit_b, w_fwd_b} = forward_operand(i_in_rt, i_rf_port_b);
  end

  // Load-use detection and handshake; rt only matters when B is not the immediate.
  always_comb begin
    w_hazard = i_in_valid && r_out_valid && r_out_is_load && (r_out_dest != ZERO_IDX) &&
               ((r_out_dest == i_in_rs) || (!i_in_use_imm && (r_out_dest == i_in_rt)));
    w_advance  = !r_out_valid || i_out_ready;
    o_in_ready = w_advance && !w_hazard && !i_reset;
  end

  // ID/EX pipeline register: reset, flush, bubble, capture, drain or hold.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out_valid      <= 1'b0;
      r_out_operand_a  <= {DATA_WIDTH{1'b0}};
      r_out_operand_b  <= {DATA_WIDTH{1'b0}};
      r_out_store_data <= {DATA_WIDTH{1'b0}};
      r_out_dest       <= ZERO_IDX;
      r_out_reg_write  <= 1'b0;
      r_out_is_load    <= 1'b0;
    end else if (i_flush) begin
      r_out_valid <= 1'b0;
    end else if (w_advance && w_hazard) begin
      // Bubble; the dependent instruction stays on the input for one more cycle.
      r_out_valid <= 1'b0;
    end else if (w_advance && i_in_valid) begin
      r_out_valid      <= 1'b1;
      r_out_operand_a  <= w_fwd_a;
      r_out_operand_b  <= i_in_use_imm ? i_in_imm : w_fwd_b;
      r_out_store_data <= w_fwd_b;
      r_out_dest       <= i_in_rd;
      r_out_reg_write  <= i_in_reg_write;
      r_out_is_load    <= i_in_is_load;
    end else if (w_advance) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign o_out_valid      = r_out_valid;
  assign o_out_operand_a  = r_out_operand_a;
  assign o_out_operand_b  = r_out_operand_b;
  assign o_out_store_data = r_out_store_data;
  assign o_out_dest       = r_out_dest;
  assign o_out_reg_write  = r_out_reg_write;
  assign o_out_is_load    = r_out_is_load;

`ifdef OPERAND_FETCH_STATS_EN
  logic [31:0] r_stall_count;
  logic [31:0] r_forward_count;
  logic        w_accept;

  assign w_accept = w_advance && i_in_valid && !w_hazard && !i_flush;

  // Saturating stall and forward counters, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_count   <= 32'd0;
      r_forward_count <= 32'd0;
    end else begin
      if (w_advance && w_hazard && !i_flush && (r_stall_count != 32'hFFFF_FFFF)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end else begin
        r_stall_count <= r_stall_count;
      end
      if (w_accept && (w_hit_a || w_hit_b) && (r_forward_count != 32'hFFFF_FFFF)) begin
        r_forward_count <= r_forward_count + 32'd1;
      end else begin
        r_forward_count <= r_forward_count;
      end
    end
  end

  assign o_stall_count   = r_stall_count;
  assign o_forward_count = r_forward_count;
`endif

endmodule
